// File: rtl/gb_pkg.sv
// Shared types for the global-buffer bank ID translator: category tags,
// FSM states and default geometry.
package gb_pkg;

   typedef enum logic [1:0] {
      CAT_WEI    = 2'd0,
      CAT_FLGWEI = 2'd1,
      CAT_ACT    = 2'd2,
      CAT_FLGACT = 2'd3
   } gb_cat_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      READY = 2'd2
   } gb_state_e;

   localparam int GB_NUM_CAT  = 4;
   localparam int GB_NUM_BANK = 16;
   localparam int GB_CNT_W    = 4;

endpackage

// File: rtl/gb_bank_id_map_if.sv
// Config and translate/response handshake bundle of the bank ID translator.
interface gb_bank_id_map_if #(
   parameter int NUM_CAT  = 4,
   parameter int NUM_BANK = 16,
   parameter int CNT_W    = 4
);
   localparam int TAG_W  = $clog2(NUM_CAT);
   localparam int BANK_W = $clog2(NUM_BANK);

   logic                      cfg_vld;
   logic                      cfg_rdy;
   logic [NUM_CAT*CNT_W-1:0]  cfg_num;
   logic                      cfg_done;
   logic                      cfg_err;
   logic                      req_vld;
   logic                      req_rdy;
   logic [TAG_W-1:0]          req_cat;
   logic [CNT_W-1:0]          req_id;
   logic                      rsp_vld;
   logic                      rsp_rdy;
   logic [TAG_W+BANK_W-1:0]   rsp_abs;
   logic                      rsp_err;

   modport master (
      output cfg_vld, cfg_num, req_vld, req_cat, req_id, rsp_rdy,
      input  cfg_rdy, cfg_done, cfg_err, req_rdy, rsp_vld, rsp_abs, rsp_err
   );

   modport slave (
      input  cfg_vld, cfg_num, req_vld, req_cat, req_id, rsp_rdy,
      output cfg_rdy, cfg_done, cfg_err, req_rdy, rsp_vld, rsp_abs, rsp_err
   );

endinterface

// File: rtl/gb_bank_base_accum.sv
// Prefix-sum engine: walks the categories one per cycle, storing each
// category's base and exposing the running total on the final step.
module gb_bank_base_accum
   import gb_pkg::*;
#(
   parameter int NUM_CAT = GB_NUM_CAT,
   parameter int CNT_W   = GB_CNT_W,
   parameter int ACC_W   = CNT_W + $clog2(NUM_CAT) + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_start,
   input  logic                             i_active,
   input  logic [NUM_CAT-1:0][CNT_W-1:0]    i_num,
   output logic [NUM_CAT-1:0][ACC_W-1:0]    o_base,
   output logic [ACC_W-1:0]                 o_total,
   output logic                             o_done
);
   localparam int K_W = (NUM_CAT > 1) ? $clog2(NUM_CAT) : 1;

   logic [ACC_W-1:0]                 r_acc;
   logic [K_W-1:0]                   r_k;
   logic [NUM_CAT-1:0][ACC_W-1:0]    r_base;
   logic [ACC_W-1:0]                 w_sum;

   assign w_sum   = r_acc + ACC_W'(i_num[r_k]);
   assign o_done  = i_active && (r_k == K_W'(NUM_CAT - 1));
   // Total is the post-add value so the caller can judge it on the last step
   assign o_total = w_sum;
   assign o_base  = r_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= '0;
         r_k    <= '0;
         r_base <= '0;
      end else if (i_start) begin
         r_acc <= '0;
         r_k   <= '0;
      end else if (i_active) begin
         r_base[r_k] <= r_acc;
         r_acc       <= w_sum;
         r_k         <= o_done ? '0 : r_k + K_W'(1);
      end
   end

endmodule

// File: rtl/gb_bank_id_map.sv
// Category-relative to absolute GB bank ID translator with runtime-loaded
// per-category bank counts and a one-stage registered response.
module gb_bank_id_map
   import gb_pkg::*;
#(
   parameter int NUM_CAT  = GB_NUM_CAT,
   parameter int NUM_BANK = GB_NUM_BANK,
   parameter int CNT_W    = GB_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   gb_bank_id_map_if.slave    bus
);
   localparam int TAG_W  = $clog2(NUM_CAT);
   localparam int BANK_W = $clog2(NUM_BANK);
   localparam int ACC_W  = CNT_W + TAG_W + 1;

   gb_state_e                        r_state, w_state_nxt;
   logic [NUM_CAT-1:0][CNT_W-1:0]    r_num;
   logic [NUM_CAT-1:0][ACC_W-1:0]    w_base;
   logic [ACC_W-1:0]                 w_total;
   logic                             w_done;
   logic                             w_cfg_acc, w_cfg_ok, w_cfg_bad;
   logic                             r_cfg_done, r_cfg_err;

   logic                             w_req_acc, w_cat_ok, w_err;
   logic [ACC_W-1:0]                 w_sum;
   logic [TAG_W+BANK_W-1:0]          w_abs;
   logic                             r_rsp_vld, r_rsp_err;
   logic [TAG_W+BANK_W-1:0]          r_rsp_abs;

   assign bus.cfg_rdy  = (r_state == IDLE) || (r_state == READY);
   assign bus.cfg_done = r_cfg_done;
   assign bus.cfg_err  = r_cfg_err;
   assign bus.req_rdy  = (r_state == READY) && (!r_rsp_vld || bus.rsp_rdy);
   assign bus.rsp_vld  = r_rsp_vld;
   assign bus.rsp_abs  = r_rsp_abs;
   assign bus.rsp_err  = r_rsp_err;

   assign w_cfg_acc = bus.cfg_vld && bus.cfg_rdy;
   assign w_req_acc = bus.req_vld && bus.req_rdy;

   gb_bank_base_accum #(
      .NUM_CAT (NUM_CAT),
      .CNT_W   (CNT_W),
      .ACC_W   (ACC_W)
   ) u_accum (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_cfg_acc),
      .i_active (r_state == ACCUM),
      .i_num    (r_num),
      .o_base   (w_base),
      .o_total  (w_total),
      .o_done   (w_done)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cfg_ok    = 1'b0;
      w_cfg_bad   = 1'b0;
      case (r_state)
         IDLE, READY: begin
            if (w_cfg_acc) w_state_nxt = ACCUM;
         end
         ACCUM: begin
            if (w_done) begin
               // An oversubscribed config drops back to IDLE, locking out requests
               if (w_total <= ACC_W'(NUM_BANK)) begin
                  w_state_nxt = READY;
                  w_cfg_ok    = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_cfg_bad   = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_num      <= '0;
         r_cfg_done <= 1'b0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cfg_done <= w_cfg_ok;
         r_cfg_err  <= w_cfg_bad;
         if (w_cfg_acc) r_num <= bus.cfg_num;
      end
   end

   assign w_cat_ok = ({1'b0, bus.req_cat} < (TAG_W + 1)'(NUM_CAT));
   assign w_sum    = w_base[bus.req_cat] + ACC_W'(bus.req_id);
   assign w_err    = !w_cat_ok || (bus.req_id >= r_num[bus.req_cat]);
   assign w_abs    = w_err ? '0 : {bus.req_cat, w_sum[BANK_W-1:0]};

   // Output register holds until consumed; a same-cycle consume+accept reloads it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_vld <= 1'b0;
         r_rsp_abs <= '0;
         r_rsp_err <= 1'b0;
      end else if (w_req_acc) begin
         r_rsp_vld <= 1'b1;
         r_rsp_abs <= w_abs;
         r_rsp_err <= w_err;
      end else if (bus.rsp_rdy) begin
         r_rsp_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gb_bank_id_map.sv
// Directed scoreboard bench for gb_bank_id_map: config latency, translation,
// range errors, throughput, backpressure, reconfiguration and reset.
module tb_gb_bank_id_map;
   import gb_pkg::*;

   localparam int NUM_CAT  = GB_NUM_CAT;
   localparam int NUM_BANK = GB_NUM_BANK;
   localparam int CNT_W    = GB_CNT_W;
   localparam int TAG_W    = $clog2(NUM_CAT);
   localparam int BANK_W   = $clog2(NUM_BANK);
   localparam int ABS_W    = TAG_W + BANK_W;

   typedef struct packed {
      logic [ABS_W-1:0] abs;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gb_bank_id_map_if #(.NUM_CAT(NUM_CAT), .NUM_BANK(NUM_BANK), .CNT_W(CNT_W)) bus ();

   gb_bank_id_map #(.NUM_CAT(NUM_CAT), .NUM_BANK(NUM_BANK), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];
   int   m_num[NUM_CAT];
   int   m_base[NUM_CAT];
   logic hs_req, hs_rsp;
   logic [ABS_W-1:0] held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit model_cfg(input logic [NUM_CAT*CNT_W-1:0] cn);
      int acc = 0;
      for (int c = 0; c < NUM_CAT; c++) begin
         m_num[c]  = int'(cn[c*CNT_W +: CNT_W]);
         m_base[c] = acc;
         acc      += m_num[c];
      end
      return acc <= NUM_BANK;
   endfunction

   function automatic exp_t exp_of(input int cat, input int id);
      exp_t e;
      logic [BANK_W-1:0] lo;
      lo    = BANK_W'(m_base[cat] + id);
      e.err = (cat >= NUM_CAT) || (id >= m_num[cat]);
      e.abs = e.err ? '0 : {TAG_W'(cat), lo};
      return e;
   endfunction

   // Sample handshakes and outputs mid-cycle, then step past the next edge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      hs_rsp = bus.rsp_vld && bus.rsp_rdy;
      hs_req = bus.req_vld && bus.req_rdy;
      if (hs_rsp) begin
         chk("sb_nonempty", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_abs", 32'(bus.rsp_abs), 32'(e.abs));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
      if (hs_req) sb.push_back(exp_of(int'(bus.req_cat), int'(bus.req_id)));
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int cat, input int id);
      bus.req_vld = 1'b1;
      bus.req_cat = TAG_W'(cat);
      bus.req_id  = CNT_W'(id);
      for (int t = 0; t < 20; t++) begin
         tick();
         if (hs_req) break;
      end
      chk("req_accept", 32'(hs_req), 1);
      bus.req_vld = 1'b0;
   endtask

   task automatic drain();
      bus.rsp_rdy = 1'b1;
      bus.req_vld = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (!bus.rsp_vld && sb.size() == 0) break;
         tick();
      end
      chk("drain_empty", 32'(sb.size()), 0);
   endtask

   task automatic do_cfg(input logic [NUM_CAT*CNT_W-1:0] cn);
      bit ok;
      int k;
      ok          = model_cfg(cn);
      bus.cfg_num = cn;
      bus.cfg_vld = 1'b1;
      @(negedge clk);
      chk("cfg_rdy_idle", 32'(bus.cfg_rdy), 1);
      @(posedge clk);
      #1;
      bus.cfg_vld = 1'b0;
      k = 0;
      while (!(bus.cfg_done || bus.cfg_err) && k < 12) begin
         if (k == 1) chk("cfg_rdy_accum", 32'(bus.cfg_rdy), 0);
         @(posedge clk);
         #1;
         k++;
      end
      chk("cfg_latency", 32'(k), NUM_CAT);
      chk("cfg_done", 32'(bus.cfg_done), 32'(ok));
      chk("cfg_err", 32'(bus.cfg_err), 32'(!ok));
      if (!bus.rsp_vld) chk("req_rdy_after_cfg", 32'(bus.req_rdy), 32'(ok));
      @(posedge clk);
      #1;
      chk("cfg_pulse_end", 32'(bus.cfg_done || bus.cfg_err), 0);
   endtask

   task automatic chk_reset();
      chk("rst_cfg_rdy", 32'(bus.cfg_rdy), 1);
      chk("rst_cfg_done", 32'(bus.cfg_done), 0);
      chk("rst_cfg_err", 32'(bus.cfg_err), 0);
      chk("rst_req_rdy", 32'(bus.req_rdy), 0);
      chk("rst_rsp_vld", 32'(bus.rsp_vld), 0);
      chk("rst_rsp_abs", 32'(bus.rsp_abs), 0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 0);
   endtask

   initial begin
      bus.cfg_vld = 1'b0;
      bus.cfg_num = '0;
      bus.req_vld = 1'b0;
      bus.req_cat = '0;
      bus.req_id  = '0;
      bus.rsp_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset();
      rst = 1'b0;
      bus.rsp_rdy = 1'b1;

      // wei=4, flgwei=2, act=6, flgact=2 -> bases 0,4,6,12
      do_cfg(16'h2624);
      send(1, 1);
      chk("abs_c1_i1", 32'(bus.rsp_abs), 32'h15);
      send(3, 1);
      chk("abs_c3_i1", 32'(bus.rsp_abs), 32'h3D);
      send(2, 6);
      chk("err_c2_i6", 32'(bus.rsp_err), 1);
      for (int c = 0; c < NUM_CAT; c++) send(c, 0);
      send(0, 3);
      send(0, 4);
      drain();

      // Oversubscribed: 8+8+1+0 = 17 banks
      do_cfg(16'h0188);
      bus.req_vld = 1'b1;
      bus.req_cat = '0;
      bus.req_id  = '0;
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("bad_cfg_no_accept", 32'(hs_req), 0);
         chk("bad_cfg_req_rdy", 32'(bus.req_rdy), 0);
      end
      bus.req_vld = 1'b0;

      do_cfg(16'h2624);
      bus.rsp_rdy = 1'b1;
      bus.req_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.req_cat = TAG_W'(i % NUM_CAT);
         bus.req_id  = CNT_W'(i % 3);
         tick();
         chk("b2b_accept", 32'(hs_req), 1);
      end
      bus.req_vld = 1'b0;
      drain();

      bus.rsp_rdy = 1'b0;
      send(3, 0);
      held = bus.rsp_abs;
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("bp_abs_hold", 32'(bus.rsp_abs), 32'(held));
         chk("bp_rsp_vld", 32'(bus.rsp_vld), 1);
         chk("bp_req_rdy", 32'(bus.req_rdy), 0);
      end

      // Reconfigure with the response still held
      do_cfg(16'h4444);
      chk("reconf_abs_hold", 32'(bus.rsp_abs), 32'(held));
      chk("reconf_rsp_vld", 32'(bus.rsp_vld), 1);
      bus.rsp_rdy = 1'b1;
      send(2, 3);
      chk("abs_new_base", 32'(bus.rsp_abs), 32'h2B);
      send(3, 4);
      send(0, 3);
      drain();

      // Reset during the second ACCUM cycle with a response pending
      bus.rsp_rdy = 1'b0;
      send(1, 0);
      bus.cfg_num = 16'h2624;
      bus.cfg_vld = 1'b1;
      @(posedge clk);
      #1;
      bus.cfg_vld = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset();
      sb.delete();
      rst = 1'b0;
      bus.rsp_rdy = 1'b1;
      do_cfg(16'h2624);
      send(1, 1);
      chk("abs_after_rst", 32'(bus.rsp_abs), 32'h15);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gb_bank_id_map.md
# gb_bank_id_map

Parametrised, registered translator from category-relative SRAM bank IDs (weight, weight-flag, activation, activation-flag, …) to absolute global-buffer bank IDs. Per-category bank counts are loaded through a config handshake, and a small FSM computes the category base offsets one per cycle. Translation requests then pass through a one-stage valid/ready pipeline that checks each ID against its range. It sits between the GB access arbiters and the SRAM bank decoder and replaces the fixed 4-category combinational mapper.

## Interface
Parameters:
- NUM_CAT, 4: number of bank categories; category tag width TAG_W = $clog2(NUM_CAT).
- NUM_BANK, 16: total physical banks; BANK_W = $clog2(NUM_BANK).
- CNT_W, 4: width of each per-category bank count and of the relative ID.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_vld  in  1  config valid.
- cfg_rdy  out  1  config ready; high in IDLE and READY.
- cfg_num  in  NUM_CAT*CNT_W  packed bank counts; category c occupies bits [c*CNT_W +: CNT_W].
- cfg_done  out  1  one-cycle pulse when a valid config has been installed.
- cfg_err  out  1  one-cycle pulse when the config was rejected.
- req_vld  in  1  translation request valid.
- req_rdy  out  1  translation request ready.
- req_cat  in  TAG_W  category of the request.
- req_id  in  CNT_W  relative bank ID within the category.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_abs  out  TAG_W+BANK_W  absolute ID = {req_cat, base[req_cat]+req_id}.
- rsp_err  out  1  request was out of range.

## Operation
- FSM states and transitions:
  - IDLE → ACCUM on cfg_vld&&cfg_rdy; cfg_num is latched into num[] and the accumulator is cleared.
  - ACCUM lasts NUM_CAT cycles. Cycle k does base[k] ← acc, then acc ← acc + num[k].
  - acc width is CNT_W+TAG_W+1, so it never wraps.
  - After the last ACCUM cycle, if acc ≤ NUM_BANK: go to READY and pulse cfg_done.
  - Otherwise: go to IDLE, pulse cfg_err, and leave base[] invalid so no requests are accepted.
  - READY → ACCUM on cfg_vld (reconfiguration).
- A zero count for a category is legal; any request to that category sets rsp_err.
- Requests are accepted only when req_rdy = (state==READY) && (!rsp_vld || rsp_rdy).
- On acceptance, the output register loads:
  - rsp_err = (req_id ≥ num[req_cat]) || (req_cat ≥ NUM_CAT).
  - rsp_abs = rsp_err ? 0 : {req_cat, (base+req_id)[BANK_W-1:0]}.
- Reconfiguration while rsp_vld=1 does not disturb the held response: it stays stable until rsp_rdy.

## Timing
- Reset values: state=IDLE; cfg_rdy=1; cfg_done=0; cfg_err=0; req_rdy=0; rsp_vld=0; rsp_abs=0; rsp_err=0; num[] and base[]=0.
- Config latency:
  - cfg_vld is accepted at edge T.
  - cfg_done or cfg_err is high during cycle T+NUM_CAT+1.
  - req_rdy can first be high in that same cycle.
- cfg_vld is ignored while in ACCUM, because cfg_rdy=0 there.
- Request latency is 1 cycle: a request accepted at edge T gives rsp_vld=1 from T+1.
- Full throughput: when rsp_rdy=1 continuously, one request is accepted per cycle.
- Backpressure: when rsp_vld=1 and rsp_rdy=0, req_rdy=0 and rsp_* hold stable.
- Simultaneous rsp handshake and new request acceptance in the same cycle: the register reloads, and rsp_vld stays 1.
- rst mid-ACCUM or with a pending response returns to the reset values on the next edge; in-flight data is discarded.

## Structure
- Shared package gb_pkg holds:
  - Category enum: CAT_WEI=0, CAT_FLGWEI=1, CAT_ACT=2, CAT_FLGACT=3.
  - FSM state typedef (IDLE, ACCUM, READY).
  - Default NUM_BANK and CNT_W.
- One sub-module, gb_bank_base_accum, contains the ACCUM counter and prefix-sum datapath and exposes base[], total and done.
- Handshake and the output register stay in the top module.

## Test plan
- cfg_num {flgact=2, act=6, flgwei=2, wei=4}: bases must be 0,4,6,12, with cfg_done at T+5. Request cat=1, id=1 must give rsp_abs=6'h15 and rsp_err=0.
- Same config, request cat=3, id=1: rsp_abs=6'h3D. Request cat=2, id=6: rsp_err=1 and rsp_abs=0.
- Config {0,1,8,8} (total 17 > 16): must give a cfg_err pulse, cfg_done never asserted, and req_rdy staying 0.
- Back-to-back stream of 8 requests with rsp_rdy=1: one response per cycle, in order. Then hold rsp_rdy=0 for 3 cycles: rsp_abs stays stable and req_rdy=0.
- Reconfigure from READY while a response is held: the held response is unchanged; new bases apply from the first request accepted after cfg_done.
- Assert rst during ACCUM cycle 2: the next cycle shows all reset values, and a fresh config then completes normally.
